// File: rtl/data_memory_pkg.sv
// Shared types and defaults for the block-transfer data memory.
package data_memory_pkg;

  typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, DONE} state_e;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_BLOCK_WORDS    = 4;
  localparam int DEF_ACCESS_LATENCY = 5;

  // Block-address width: word address minus the in-block word offset.
  function automatic int block_addr_width(input int addr_width, input int block_words);
    return addr_width - $clog2(block_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Block-organised storage: one row per block, so a whole block is written
// or read per cycle. No reset; contents come from the owner's clear sweep.
module dmem_array
  import data_memory_pkg::*;
#(
  parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int  ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int  BLOCK_WORDS = DEF_BLOCK_WORDS,
  localparam int BA          = block_addr_width(ADDR_WIDTH, BLOCK_WORDS),
  localparam int BW          = DATA_WIDTH * BLOCK_WORDS,
  localparam int NB          = 2 ** BA
) (
  input  logic          clk,
  input  logic          we,
  input  logic [BA-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic          re,
  input  logic [BA-1:0] raddr,
  output logic [BW-1:0] rdata
);

  // Row r holds words r*BLOCK_WORDS .. r*BLOCK_WORDS+BLOCK_WORDS-1, word j in slice j.
  logic [BW-1:0] mem [NB];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/block_data_memory.sv
// Block-transfer backing store: clear sweep after reset, then one block read
// or write per request with a fixed ACCESS_LATENCY busywait window.
module block_data_memory
  import data_memory_pkg::*;
#(
  parameter int  DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int  ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int  BLOCK_WORDS    = DEF_BLOCK_WORDS,
  parameter int  ACCESS_LATENCY = DEF_ACCESS_LATENCY,
  localparam int BA             = block_addr_width(ADDR_WIDTH, BLOCK_WORDS),
  localparam int BW             = DATA_WIDTH * BLOCK_WORDS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          read,
  input  logic          write,
  input  logic [BA-1:0] address,
  input  logic [BW-1:0] writedata,
  output logic [BW-1:0] readdata,
  output logic          busywait,
  output logic          error
);

  localparam int            LW       = $clog2(ACCESS_LATENCY + 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(ACCESS_LATENCY - 1);

  state_e        state_q, state_d;
  logic [BA-1:0] clr_cnt_q, clr_cnt_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [BA-1:0] addr_q, addr_d;
  logic [BW-1:0] wdata_q, wdata_d;
  logic [BW-1:0] rdata_q, rdata_d;
  logic          is_wr_q, is_wr_d;
  logic          error_q, error_d;

  logic          accept, last_access;
  logic          arr_we;
  logic [BA-1:0] arr_waddr;
  logic [BW-1:0] arr_wdata, arr_rdata;

  assign accept      = (state_q == IDLE) && (read ^ write);
  assign last_access = (state_q == ACCESS) && (lat_cnt_q == '0);

  // The clear sweep and the access commit share the array's single write port.
  assign arr_we    = (state_q == CLEAR) || (last_access && is_wr_q);
  assign arr_waddr = (state_q == CLEAR) ? clr_cnt_q : addr_q;
  assign arr_wdata = (state_q == CLEAR) ? '0 : wdata_q;

  // The block is fetched on the accept edge; nothing else writes the array
  // during ACCESS, so the fetched row is still current when it is published.
  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BLOCK_WORDS(BLOCK_WORDS)
  ) u_array (
    .clk  (clock),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .re   (accept),
    .raddr(address),
    .rdata(arr_rdata)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    lat_cnt_d = lat_cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    rdata_d   = rdata_q;
    error_d   = 1'b0;
    busywait  = 1'b1;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + BA'(1);
        if (clr_cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        busywait = read ^ write;
        error_d  = read & write;
        if (accept) begin
          addr_d    = address;
          wdata_d   = writedata;
          is_wr_d   = write;
          lat_cnt_d = LAT_LOAD;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt_q == '0) begin
          state_d = DONE;
          if (!is_wr_q) rdata_d = arr_rdata;
        end else begin
          lat_cnt_d = lat_cnt_q - LW'(1);
        end
      end
      DONE: begin
        busywait = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      lat_cnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      is_wr_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      is_wr_q   <= is_wr_d;
      error_q   <= error_d;
    end
  end

  assign readdata = rdata_q;
  assign error    = error_q;

endmodule

// File: tb/tb_block_data_memory.sv
// Self-checking bench for block_data_memory against a word-array reference model.
module tb_block_data_memory;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [5:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        busywait;
  logic        error;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem_m [256];
  logic [31:0] rd_m;

  always #5 clock = ~clock;

  block_data_memory #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .BLOCK_WORDS(4), .ACCESS_LATENCY(5)
  ) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .error(error)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model_block(input logic [5:0] a);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = mem_m[int'(a) * 4 + j];
    return r;
  endfunction

  function automatic void model_write(input logic [5:0] a, input logic [31:0] d);
    for (int j = 0; j < 4; j++) mem_m[int'(a) * 4 + j] = d[8*j +: 8];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    rd_m = '0;
  endfunction

  // Called on the negedge where reset is released; counts busy cycles to IDLE.
  task automatic wait_clear(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busywait) break;
      n++;
      @(negedge clock);
    end
  endtask

  // Issues one request and returns at the negedge of DONE, with the number
  // of cycles busywait was high (request cycle included).
  task automatic do_req(input bit wr, input logic [5:0] a, input logic [31:0] d,
                        output int busy);
    @(negedge clock);
    read = !wr; write = wr; address = a; writedata = d;
    busy = 0;
    #1;
    if (busywait) busy = 1;
    @(posedge clock);
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busywait) break;
      busy++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clock);
    checks++; if (busywait !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", busywait); end
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL rst_readdata got=%h exp=0", readdata); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", error); end
    reset = 1'b1;
    wait_clear(n);
    checks++; if (n != 64) begin failures++; $display("FAIL clear_cycles got=%0d exp=64", n); end
    model_clear();
  endtask

  task automatic test_clear_read();
    int busy;
    do_req(1'b0, 6'h3F, 32'h0, busy);
    rd_m = model_block(6'h3F);
    checks++; if (busy != 6) begin failures++; $display("FAIL clr_rd_busy got=%0d exp=6", busy); end
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL clr_rd_data got=%h exp=0", readdata); end
  endtask

  task automatic test_write_read();
    int busy;
    do_req(1'b1, 6'h05, 32'hDDCCBBAA, busy);
    model_write(6'h05, 32'hDDCCBBAA);
    checks++; if (busy != 6) begin failures++; $display("FAIL wr_busy got=%0d exp=6", busy); end
    checks++; if (readdata !== rd_m) begin failures++; $display("FAIL wr_keeps_rd got=%h exp=%h", readdata, rd_m); end
    do_req(1'b0, 6'h05, 32'h0, busy);
    rd_m = model_block(6'h05);
    checks++; if (busy != 6) begin failures++; $display("FAIL rd_busy got=%0d exp=6", busy); end
    checks++; if (readdata !== 32'hDDCCBBAA) begin failures++; $display("FAIL rd_data got=%h exp=ddccbbaa", readdata); end
  endtask

  task automatic test_conflict();
    int busy;
    @(negedge clock);
    read = 1'b1; write = 1'b1; address = 6'h05; writedata = $urandom;
    #1;
    checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL conf_busy got=%b exp=0", busywait); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL conf_err_early got=%b exp=0", error); end
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL conf_err got=%b exp=1", error); end
    checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL conf_busy2 got=%b exp=0", busywait); end
    @(negedge clock);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL conf_err_len got=%b exp=0", error); end
    do_req(1'b0, 6'h05, 32'h0, busy);
    rd_m = model_block(6'h05);
    checks++; if (readdata !== rd_m) begin failures++; $display("FAIL conf_mem got=%h exp=%h", readdata, rd_m); end
  endtask

  task automatic test_held_read();
    int busy;
    @(negedge clock);
    read = 1'b1; address = 6'h05;
    busy = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (!busywait) break;
      busy++;
      @(negedge clock);
    end
    rd_m = model_block(6'h05);
    checks++; if (busy != 6) begin failures++; $display("FAIL held_busy got=%0d exp=6", busy); end
    checks++; if (readdata !== rd_m) begin failures++; $display("FAIL held_data got=%h exp=%h", readdata, rd_m); end
    // read still high in DONE; next cycle is IDLE and the held read is a new request
    @(negedge clock);
    address = 6'h3F;
    #1;
    checks++; if (busywait !== 1'b1) begin failures++; $display("FAIL held_idle_busy got=%b exp=1", busywait); end
    busy = 1;
    @(posedge clock);
    @(negedge clock);
    read = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busywait) break;
      busy++;
      @(negedge clock);
    end
    rd_m = model_block(6'h3F);
    checks++; if (busy != 6) begin failures++; $display("FAIL held_second_busy got=%0d exp=6", busy); end
    checks++; if (readdata !== rd_m) begin failures++; $display("FAIL held_second_data got=%h exp=%h", readdata, rd_m); end
  endtask

  task automatic test_addr_change();
    int busy;
    logic [31:0] d;
    d = $urandom | 32'h1;
    @(negedge clock);
    write = 1'b1; address = 6'h02; writedata = d;
    @(negedge clock);
    write = 1'b0;
    @(negedge clock);
    address = 6'h07; writedata = ~d;
    repeat (4) @(negedge clock);
    model_write(6'h02, d);
    checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL chg_done got=%b exp=0", busywait); end
    do_req(1'b0, 6'h07, 32'h0, busy);
    rd_m = model_block(6'h07);
    checks++; if (readdata !== rd_m) begin failures++; $display("FAIL chg_blk7 got=%h exp=%h", readdata, rd_m); end
    do_req(1'b0, 6'h02, 32'h0, busy);
    rd_m = model_block(6'h02);
    checks++; if (readdata !== rd_m) begin failures++; $display("FAIL chg_blk2 got=%h exp=%h", readdata, rd_m); end
  endtask

  task automatic test_reset_abort();
    int busy, n;
    @(negedge clock);
    write = 1'b1; address = 6'h0A; writedata = $urandom | 32'h100;
    @(negedge clock);
    write = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (busywait !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", busywait); end
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL abort_rd got=%h exp=0", readdata); end
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    wait_clear(n);
    checks++; if (n != 64) begin failures++; $display("FAIL abort_clear got=%0d exp=64", n); end
    do_req(1'b0, 6'h0A, 32'h0, busy);
    rd_m = model_block(6'h0A);
    checks++; if (readdata !== rd_m) begin failures++; $display("FAIL abort_blkA got=%h exp=%h", readdata, rd_m); end
    do_req(1'b0, 6'h05, 32'h0, busy);
    rd_m = model_block(6'h05);
    checks++; if (readdata !== rd_m) begin failures++; $display("FAIL abort_blk5 got=%h exp=%h", readdata, rd_m); end
  endtask

  task automatic test_random();
    int busy;
    bit wr;
    logic [5:0] a;
    logic [31:0] d;
    for (int k = 0; k < 40; k++) begin
      wr = 1'($urandom_range(0, 1));
      a  = (k % 4 == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      d  = $urandom;
      do_req(wr, a, d, busy);
      if (wr) model_write(a, d);
      else rd_m = model_block(a);
      checks++; if (busy != 6) begin failures++; $display("FAIL rnd_busy op=%0d got=%0d exp=6", k, busy); end
      checks++; if (readdata !== rd_m) begin failures++; $display("FAIL rnd_data op=%0d got=%h exp=%h", k, readdata, rd_m); end
    end
  endtask

  initial begin
    test_reset();
    test_clear_read();
    test_write_read();
    test_conflict();
    test_held_read();
    test_addr_change();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
